memory_stage: RTL and testbench
===============================

MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- valid_in  in  1  execute-stage result present this cycle.
- alu_res  in  32  effective address for load/store; pass-through result otherwise.
- mem_data  in  32  store data (forwarded rs2 value).
- mem_read  in  1  instruction is a load.
- mem_write  in  1  instruction is a store.
- funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- dmem_req  out  1  data-memory request.
- dmem_we  out  1  request is a write.
- dmem_addr  out  32  word-aligned address {addr[31:2],2'b00}.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_ready  in  1  memory accepts/completes the request this cycle.
- dmem_rdata  in  32  read data, valid when dmem_ready=1 on a read.
- stall  out  1  upstream SHALL hold its outputs while high.
- mem_res  out  32  writeback value.
- mem_res_valid  out  1  one-cycle pulse, mem_res valid.
- misaligned  out  1  one-cycle pulse, misaligned access rejected.

Function
REQ-003 FSM SHALL have two states: IDLE and ACCESS; stall = (state==ACCESS), registered-state decode only.
REQ-004 In IDLE with valid_in=1 and no memory op: mem_res <= alu_res, mem_res_valid pulses next cycle (latency 1), stay IDLE.
REQ-005 In IDLE with valid_in=1 and aligned memory op: capture address, data, size, direction; go ACCESS next cycle.
REQ-006 mem_write=1 SHALL take priority when mem_read and mem_write are both 1.
REQ-007 funct3 values 011, 110, 111 SHALL be treated as word access.
REQ-008 Misalignment: H/HU with addr[0]=1, W with addr[1:0]!=0; SHALL issue no request, pulse misaligned next cycle, no mem_res_valid, stay IDLE.
REQ-009 In ACCESS: dmem_req=1; dmem_we, dmem_addr, dmem_be, dmem_wdata SHALL be driven from captured registers and held stable until dmem_ready=1.
REQ-010 In ACCESS, valid_in and all execute inputs SHALL be ignored.
REQ-011 Byte enables: B/BU 4'b0001<<addr[1:0]; H/HU 4'b0011<<{addr[1],1'b0}; W 4'b1111; same rule for loads and stores.
REQ-012 Store data: B {4{mem_data[7:0]}}; H {2{mem_data[15:0]}}; W mem_data.
REQ-013 Load result: select lane by addr[1:0] (B) or addr[1] (H); sign-extend for B/H, zero-extend for BU/HU, word unchanged.
REQ-014 In ACCESS with dmem_ready=1: return to IDLE next cycle; mem_res_valid pulses next cycle; mem_res = extracted load data for loads, captured alu_res for stores.
REQ-015 Minimum memory-op latency: capture at T, dmem_req at T+1, dmem_ready at T+1 gives mem_res_valid at T+2.
REQ-016 dmem_ready while in IDLE SHALL be ignored.
REQ-017 mem_res SHALL hold its last value when mem_res_valid=0.

Reset
REQ-018 While rst=1, asynchronously: state=IDLE; stall, dmem_req, dmem_we, mem_res_valid, misaligned = 0; dmem_addr, dmem_be, dmem_wdata, mem_res = 0.
REQ-019 rst asserted in ACCESS SHALL drop dmem_req immediately; the aborted access SHALL produce no mem_res_valid after release.

Verification
REQ-020 ALU pass-through: valid_in=1, no mem op, alu_res=0x1234_5678 -> next cycle mem_res=0x1234_5678, mem_res_valid=1 for one cycle, stall=0 throughout.
REQ-021 LB with wait states: addr=0x0000_1003, funct3=000, dmem_ready low 3 cycles then high, rdata=0x8000_0000 -> dmem_addr=0x0000_1000, be=4'b1000, stall=1 for 4 cycles, mem_res=0xFFFF_FF80.
REQ-022 SH: addr=0x0000_2002, mem_data=0xDEAD_BEEF, ready immediate -> dmem_we=1, be=4'b1100, wdata=0xBEEF_BEEF, mem_res_valid at T+2.
REQ-023 Misaligned LW: addr=0x0000_0006, funct3=010 -> misaligned=1 next cycle, dmem_req never asserted, mem_res_valid=0.
REQ-024 LHU: addr=0x10, rdata=0x0000_F00D -> mem_res=0x0000_F00D; LH same -> 0xFFFF_F00D.
REQ-025 Reset during ACCESS with dmem_ready=0 -> dmem_req=0 same cycle, no mem_res_valid after release, next valid_in accepted in IDLE.

Source files
------------

// File: rtl/memory_stage.sv
// Memory stage of a simple in-order pipeline.
// Passes non-memory results straight through with one cycle of latency.
// Turns loads/stores into a single data-memory request: address, byte
// enables and lane-replicated store data are captured in IDLE and held
// steady in ACCESS until the memory answers.
//
// Handshake: in ACCESS, dmem_req stays high and every request field stays
// frozen until a cycle with dmem_ready=1. That cycle completes the transfer.
// A read returns its data on dmem_rdata in that same cycle. dmem_ready is
// ignored in IDLE. Upstream must hold its outputs while stall is high.
module memory_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [31:0] alu_res,
  input  logic [31:0] mem_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic [31:0] mem_res,
  output logic        mem_res_valid,
  output logic        misaligned
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  lane_q, lane_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] mem_res_q, mem_res_d;
  logic        mem_res_valid_q, mem_res_valid_d;
  logic        misaligned_q, misaligned_d;

  // Access-size decode of the incoming instruction.
  // funct3[1:0] of 2'b11 falls into the word case.
  logic        size_b, size_h, size_w;
  logic        mem_op, addr_bad;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [31:0] rdata_shift;
  logic [31:0] load_val;

  // Decode the incoming access, then pick the next state and next outputs.
  always_comb begin
    size_b   = (funct3[1:0] == 2'b00);
    size_h   = (funct3[1:0] == 2'b01);
    size_w   = !size_b && !size_h;
    mem_op   = mem_read || mem_write;
    addr_bad = (size_h && alu_res[0]) || (size_w && (alu_res[1:0] != 2'b00));

    if (size_b) begin
      be_calc    = 4'b0001 << alu_res[1:0];
      wdata_calc = {4{mem_data[7:0]}};
    end else if (size_h) begin
      be_calc    = 4'b0011 << {alu_res[1], 1'b0};
      wdata_calc = {2{mem_data[15:0]}};
    end else begin
      be_calc    = 4'b1111;
      wdata_calc = mem_data;
    end

    // Move the addressed lane down to bit 0, then extend it per the captured size/sign.
    rdata_shift = dmem_rdata >> {lane_q, 3'b000};
    case (f3_q)
      3'b000:  load_val = {{24{rdata_shift[7]}}, rdata_shift[7:0]};
      3'b001:  load_val = {{16{rdata_shift[15]}}, rdata_shift[15:0]};
      3'b100:  load_val = {24'h0, rdata_shift[7:0]};
      3'b101:  load_val = {16'h0, rdata_shift[15:0]};
      default: load_val = dmem_rdata;
    endcase

    state_d         = state_q;
    we_d            = we_q;
    addr_d          = addr_q;
    lane_d          = lane_q;
    be_d            = be_q;
    wdata_d         = wdata_q;
    f3_d            = f3_q;
    alu_d           = alu_q;
    mem_res_d       = mem_res_q;
    mem_res_valid_d = 1'b0;
    misaligned_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (valid_in) begin
          if (!mem_op) begin
            mem_res_d       = alu_res;
            mem_res_valid_d = 1'b1;
          end else if (addr_bad) begin
            misaligned_d = 1'b1;
          end else begin
            // A store wins over a load when both flags are set.
            we_d    = mem_write;
            addr_d  = {alu_res[31:2], 2'b00};
            lane_d  = alu_res[1:0];
            be_d    = be_calc;
            wdata_d = wdata_calc;
            f3_d    = funct3;
            alu_d   = alu_res;
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (dmem_ready) begin
          state_d         = IDLE;
          mem_res_valid_d = 1'b1;
          mem_res_d       = we_q ? alu_q : load_val;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and all registered outputs; reset aborts any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      we_q            <= 1'b0;
      addr_q          <= 32'h0;
      lane_q          <= 2'b00;
      be_q            <= 4'h0;
      wdata_q         <= 32'h0;
      f3_q            <= 3'b000;
      alu_q           <= 32'h0;
      mem_res_q       <= 32'h0;
      mem_res_valid_q <= 1'b0;
      misaligned_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      we_q            <= we_d;
      addr_q          <= addr_d;
      lane_q          <= lane_d;
      be_q            <= be_d;
      wdata_q         <= wdata_d;
      f3_q            <= f3_d;
      alu_q           <= alu_d;
      mem_res_q       <= mem_res_d;
      mem_res_valid_q <= mem_res_valid_d;
      misaligned_q    <= misaligned_d;
    end
  end

  // The request and stall come only from the registered state, so reset drops them at once.
  assign dmem_req      = (state_q == ACCESS);
  assign stall         = (state_q == ACCESS);
  assign dmem_we       = dmem_req && we_q;
  assign dmem_addr     = addr_q;
  assign dmem_be       = be_q;
  assign dmem_wdata    = wdata_q;
  assign mem_res       = mem_res_q;
  assign mem_res_valid = mem_res_valid_q;
  assign misaligned    = misaligned_q;

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage.
// Expected results come from a byte-addressed reference memory model.
// The memory responder keeps its own word memory, which is updated only
// through the DUT's byte enables and store data. A wrong be/wdata from the
// DUT therefore shows up in later loads.
module tb_memory_stage;

  logic        clk, rst;
  logic        valid_in, mem_read, mem_write;
  logic [31:0] alu_res, mem_data;
  logic [2:0]  funct3;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        stall, mem_res_valid, misaligned;
  logic [31:0] mem_res;

  memory_stage dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .alu_res(alu_res),
    .mem_data(mem_data), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .stall(stall),
    .mem_res(mem_res), .mem_res_valid(mem_res_valid), .misaligned(misaligned)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard state ----------------
  // exp_q entry: bit 32 set = misaligned pulse expected, else mem_res value.
  logic [32:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          wait_cfg = -1;   // -1: random wait states, else fixed count

  logic [7:0]  ref_mem[logic [31:0]];   // reference model, byte addressed
  logic [31:0] word_mem[logic [29:0]];  // responder memory, word addressed

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] rm_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  function automatic logic [31:0] wm_rd(input logic [29:0] i);
    return word_mem.exists(i) ? word_mem[i] : 32'h0;
  endfunction

  function automatic int acc_bytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  // Load value = n little-endian bytes, sign-extended for signed sub-word sizes.
  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f3);
    int          n;
    logic [31:0] v;
    n = acc_bytes(f3);
    v = 32'h0;
    for (int i = 0; i < n; i++) v = v | (32'(rm_rd(a + 32'(i))) << (8 * i));
    if (n < 4 && !f3[2] && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    word_mem[a[31:2]] = v;
    for (int i = 0; i < 4; i++) ref_mem[a + 32'(i)] = v[8*i +: 8];
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_garbage();
    valid_in  = 1'($urandom_range(0, 1));
    alu_res   = $urandom;
    mem_data  = $urandom;
    mem_read  = 1'($urandom_range(0, 1));
    mem_write = 1'($urandom_range(0, 1));
    funct3    = 3'($urandom_range(0, 7));
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  // Present one instruction at the first negedge where stall is low.
  // Push what the reference model says it must produce.
  task automatic issue(input logic [31:0] a, input logic [31:0] d,
                       input logic rd, input logic wr, input logic [2:0] f3);
    int n;
    int guard;
    guard = 0;
    @(negedge clk);
    while (stall && guard < 40) begin
      drive_garbage();
      guard++;
      @(negedge clk);
    end
    if (stall) begin
      n_checks++;
      n_fail++;
      $display("FAIL stall_timeout: stall still high after %0d cycles", guard);
    end
    valid_in  = 1'b1;
    alu_res   = a;
    mem_data  = d;
    mem_read  = rd;
    mem_write = wr;
    funct3    = f3;
    n = acc_bytes(f3);
    if (!(rd || wr)) begin
      exp_q.push_back({1'b0, a});
    end else if ((n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00)) begin
      exp_q.push_back({1'b1, 32'h0});
    end else if (wr) begin
      for (int i = 0; i < n; i++) ref_mem[a + 32'(i)] = d[8*i +: 8];
      exp_q.push_back({1'b0, a});
    end else begin
      exp_q.push_back({1'b0, ref_load(a, f3)});
    end
  endtask

  // ---------------- memory responder ----------------
  // Random ready pulses in IDLE exercise the "ignored in IDLE" rule.
  initial begin : responder
    int          wcnt;
    logic        in_req;
    logic [36:0] snap_ctl;
    logic [31:0] snap_addr;
    dmem_ready = 1'b0;
    dmem_rdata = 32'h0;
    in_req     = 1'b0;
    wcnt       = 0;
    snap_ctl   = '0;
    snap_addr  = '0;
    forever begin
      @(negedge clk);
      dmem_ready = 1'b0;
      dmem_rdata = $urandom;
      if (rst || !dmem_req) begin
        in_req = 1'b0;
        if (!rst && $urandom_range(0, 3) == 0) dmem_ready = 1'b1;
      end else begin
        if (!in_req) begin
          in_req    = 1'b1;
          wcnt      = (wait_cfg >= 0) ? wait_cfg : $urandom_range(0, 3);
          snap_ctl  = {dmem_we, dmem_be, dmem_wdata};
          snap_addr = dmem_addr;
        end
        if (wcnt == 0) begin
          chk("req_hold_ctl", 64'({dmem_we, dmem_be, dmem_wdata}), 64'(snap_ctl));
          chk("req_hold_addr", 64'(dmem_addr), 64'(snap_addr));
          chk("addr_word_aligned", 64'(dmem_addr[1:0]), 64'(0));
          if (dmem_we) begin
            for (int b = 0; b < 4; b++)
              if (dmem_be[b]) begin
                word_mem[dmem_addr[31:2]][8*b +: 8] = dmem_wdata[8*b +: 8];
              end
          end else begin
            dmem_rdata = wm_rd(dmem_addr[31:2]);
          end
          dmem_ready = 1'b1;
        end else begin
          wcnt--;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (!rst && (mem_res_valid || misaligned)) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: valid=%0b misaligned=%0b mem_res=%h with nothing expected",
                   mem_res_valid, misaligned, mem_res);
        end else begin
          e = exp_q.pop_front();
          chk("out_kind", 64'({misaligned, mem_res_valid}), e[32] ? 64'(2'b10) : 64'(2'b01));
          if (!e[32]) chk("mem_res", 64'(mem_res), 64'(e[31:0]));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int op;
    int guard;
    rst = 1'b1;
    valid_in = 1'b0; alu_res = '0; mem_data = '0;
    mem_read = 1'b0; mem_write = 1'b0; funct3 = '0;
    for (int w = 0; w < 16; w++) preload(32'(w * 4), $urandom);
    preload(32'h0000_1000, 32'h8000_0000);
    preload(32'h0000_2000, 32'h0000_0000);
    preload(32'h0000_0010, 32'h0000_F00D);

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_ctl", 64'({stall, dmem_req, dmem_we, mem_res_valid, misaligned}), 64'(0));
    chk("rst_addr", 64'(dmem_addr), 64'(0));
    chk("rst_be_wdata", 64'({dmem_be, dmem_wdata}), 64'(0));
    chk("rst_mem_res", 64'(mem_res), 64'(0));
    rst = 1'b0;
    idle_cycle();

    // ALU pass-through: latency 1, one-cycle pulse, no stall, result held
    issue(32'h1234_5678, 32'h0, 1'b0, 1'b0, 3'b000);
    chk("pass_stall0", 64'(stall), 64'(0));
    idle_cycle();
    chk("pass_valid", 64'(mem_res_valid), 64'(1));
    chk("pass_stall1", 64'(stall), 64'(0));
    idle_cycle();
    chk("pass_pulse_end", 64'(mem_res_valid), 64'(0));
    chk("pass_hold", 64'(mem_res), 64'(32'h1234_5678));

    // LB with three wait states
    wait_cfg = 3;
    issue(32'h0000_1003, 32'h0, 1'b1, 1'b0, 3'b000);
    for (int c = 0; c < 4; c++) begin
      idle_cycle();
      chk("lb_stall", 64'(stall), 64'(1));
      if (c == 0) chk("lb_addr_be", 64'({dmem_addr, dmem_be}), 64'({32'h0000_1000, 4'b1000}));
    end
    idle_cycle();
    chk("lb_done", 64'({stall, mem_res_valid}), 64'(2'b01));
    chk("lb_value", 64'(mem_res), 64'(32'hFFFF_FF80));

    // SH with immediate ready: result at T+2
    wait_cfg = 0;
    issue(32'h0000_2002, 32'hDEAD_BEEF, 1'b0, 1'b1, 3'b001);
    idle_cycle();
    chk("sh_req", 64'({dmem_req, dmem_we, dmem_be}), 64'({2'b11, 4'b1100}));
    chk("sh_wdata", 64'(dmem_wdata), 64'(32'hBEEF_BEEF));
    idle_cycle();
    chk("sh_valid_t2", 64'(mem_res_valid), 64'(1));

    // Misaligned LW
    issue(32'h0000_0006, 32'h0, 1'b1, 1'b0, 3'b010);
    idle_cycle();
    chk("mis_pulse", 64'({misaligned, mem_res_valid, dmem_req}), 64'(3'b100));
    idle_cycle();
    chk("mis_after", 64'({misaligned, dmem_req, stall}), 64'(0));

    // LHU / LH of 0xF00D
    issue(32'h0000_0010, 32'h0, 1'b1, 1'b0, 3'b101);
    issue(32'h0000_0010, 32'h0, 1'b1, 1'b0, 3'b001);
    repeat (3) idle_cycle();

    // Reset during ACCESS with ready held low
    wait_cfg = 6;
    issue(32'h0000_0020, 32'h0, 1'b1, 1'b0, 3'b010);
    idle_cycle();
    chk("abort_in_access", 64'({stall, dmem_req}), 64'(2'b11));
    rst = 1'b1;
    #1;
    chk("abort_req_drop", 64'({stall, dmem_req}), 64'(0));
    void'(exp_q.pop_back());
    @(negedge clk);
    rst = 1'b0;
    repeat (4) idle_cycle();
    wait_cfg = -1;
    issue(32'hCAFE_0001, 32'h0, 1'b0, 1'b0, 3'b000);
    idle_cycle();
    chk("post_abort_accept", 64'(mem_res_valid), 64'(1));

    // Randomized mix of pass-through, loads, stores, and both flags set
    for (int t = 0; t < 400; t++) begin
      if ($urandom_range(0, 3) == 0) idle_cycle();
      op = $urandom_range(0, 3);
      if (op == 0)
        issue($urandom, $urandom, 1'b0, 1'b0, 3'($urandom_range(0, 7)));
      else
        issue(32'($urandom_range(0, 63)), $urandom, op[0], op[1], 3'($urandom_range(0, 7)));
    end

    // Drain the scoreboard
    idle_cycle();
    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      idle_cycle();
      guard++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
